ds_mod_multich: RTL

- Time-multiplexed, runtime-configurable error-feedback delta-sigma modulator serving NUM_CH independent channels through one shared adder datapath.
- Noise-shaping order is selectable per sample (0..3), and each channel keeps its own error history.
- Sits between the sample source and the per-channel PWM/DAC back ends; it replaces single-channel, fixed-order modulator instances.

---
 rtl/ds_mod_multich_if.sv | 43 ++++
 rtl/ds_mod_multich.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ds_mod_multich_if.sv
// ----------------------------------------------------------------------------
// ds_mod_multich_if
// Sample-in / code-out stream bundle for the multichannel delta-sigma
// modulator.
//   s_valid/s_ready : input sample handshake (accept on s_valid && s_ready)
//   s_ch            : channel of the input sample
//   s_u             : signed input sample (fixed point, FRAC_BITS fractional)
//   s_order         : noise-shaping order for this sample (0..3)
//   m_valid/m_ready : output handshake (consumed on m_valid && m_ready)
//   m_ch            : channel of the output code
//   m_y             : signed quantised output code
// Modports:
//   master : sample source / code sink (drives s_*, m_ready)
//   slave  : the modulator (drives s_ready, m_*)
// ----------------------------------------------------------------------------
interface ds_mod_multich_if #(
  parameter int NUM_CH   = 2,
  parameter int IN_BITS  = 16,
  parameter int OUT_BITS = 8
);
  localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  logic                       s_valid;
  logic                       s_ready;
  logic [CH_W-1:0]            s_ch;
  logic signed [IN_BITS-1:0]  s_u;
  logic [1:0]                 s_order;

  logic                       m_valid;
  logic                       m_ready;
  logic [CH_W-1:0]            m_ch;
  logic signed [OUT_BITS-1:0] m_y;

  modport master (
    output s_valid, s_ch, s_u, s_order, m_ready,
    input  s_ready, m_valid, m_ch, m_y
  );

  modport slave (
    input  s_valid, s_ch, s_u, s_order, m_ready,
    output s_ready, m_valid, m_ch, m_y
  );
endinterface

// File: rtl/ds_mod_multich.sv
// ----------------------------------------------------------------------------
// ds_mod_multich
// Time-multiplexed error-feedback delta-sigma modulator. NUM_CH channels share
// one adder; each channel keeps its own three-deep quantisation-error history.
// The shaping order (0..3) is chosen per sample:
//   y = Q(u - sum_k c_k * e_k),  e = y*2^FRAC_BITS - acc
// with c = {1}, {2,-1}, {3,-3,1} for orders 1, 2, 3 and order 0 being plain
// round-half-up. One tap is applied per cycle, so a sample of order N takes
// N+2 cycles from accept to the next accept.
//
// Ports:
//   clk   : clock
//   reset : synchronous, active-high; aborts any in-flight sample
//   bus   : ds_mod_multich_if.slave (s_valid/s_ready/s_ch/s_u/s_order in,
//           m_valid/m_ready/m_ch/m_y out)
//
// Build option:
//   DS_LFSR_DITHER_EN : adds a 16-bit Galois LFSR (x^16+x^14+x^13+x^11+1,
//   seed 0xACE1) whose low FRAC_BITS bits, re-centred on zero, are added
//   ahead of the quantiser only. The error term still uses the undithered
//   accumulator, so the dither is noise-shaped together with the
//   quantisation error.
// ----------------------------------------------------------------------------
module ds_mod_multich #(
  parameter int NUM_CH    = 2,
  parameter int IN_BITS   = 16,
  parameter int FRAC_BITS = 8,
  parameter int OUT_BITS  = 8,
  parameter int ERR_BITS  = 12
) (
  input  logic            clk,
  input  logic            reset,
  ds_mod_multich_if.slave bus
);

  localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int ACC_W = ((IN_BITS > ERR_BITS + 2) ? IN_BITS : ERR_BITS + 2) + 2;
  // One extra bit so the rounding/dither offset never wraps the quantiser sum.
  localparam int Q_W   = ACC_W + 1;
  // Wide enough for (y << FRAC_BITS) - acc without wrap.
  localparam int EQ_W  = ((ACC_W > OUT_BITS + FRAC_BITS) ? ACC_W : OUT_BITS + FRAC_BITS) + 2;

  localparam logic signed [Q_W-1:0]  HALF  = Q_W'(1 << (FRAC_BITS - 1));
  localparam logic signed [Q_W-1:0]  Y_MAX = Q_W'((1 << (OUT_BITS - 1)) - 1);
  localparam logic signed [Q_W-1:0]  Y_MIN = Q_W'(-(1 << (OUT_BITS - 1)));
  localparam logic signed [EQ_W-1:0] E_MAX = EQ_W'((1 << (ERR_BITS - 1)) - 1);
  localparam logic signed [EQ_W-1:0] E_MIN = EQ_W'(-(1 << (ERR_BITS - 1)));

  typedef enum logic [1:0] {IDLE, TAP, QUANT} state_e;
  typedef logic signed [ERR_BITS-1:0] err_t;
  typedef logic signed [ACC_W-1:0]    acc_t;

  state_e                     state_q, state_d;
  logic [CH_W-1:0]            ch_q, ch_d;
  logic [1:0]                 order_q, order_d;
  logic [1:0]                 k_q, k_d;
  acc_t                       acc_q, acc_d;
  err_t                       hist_q [NUM_CH][3];
  err_t                       hist_d [NUM_CH][3];
  logic                       m_valid_q, m_valid_d;
  logic [CH_W-1:0]            m_ch_q, m_ch_d;
  logic signed [OUT_BITS-1:0] m_y_q, m_y_d;

  logic                       s_ready;
  logic                       commit;

  // --------------------------------------------------------------------------
  // Tap datapath: c_k * e_k as (e << 1 | 0) + (e | 0), then add or subtract.
  // --------------------------------------------------------------------------
  err_t e_sel;
  acc_t e_ext, tap_term, acc_tap;
  logic tap_x1, tap_x2, tap_neg;

  always_comb begin
    // NOTE: every combinational output gets a default before any branch, so
    // no path can leave it unassigned and infer a latch.
    e_sel = '0;
    case (k_q)
      2'd1:    e_sel = hist_q[ch_q][0];
      2'd2:    e_sel = hist_q[ch_q][1];
      2'd3:    e_sel = hist_q[ch_q][2];
      default: e_sel = '0;
    endcase
  end

  always_comb begin
    tap_x1  = 1'b1;
    tap_x2  = 1'b0;
    tap_neg = 1'b0;
    case ({order_q, k_q})
      4'b01_01: ;                                      // c1 = 1
      4'b10_01: begin tap_x1 = 1'b0; tap_x2 = 1'b1; end // c1 = 2
      4'b10_10: tap_neg = 1'b1;                        // c2 = -1
      4'b11_01: tap_x2 = 1'b1;                         // c1 = 3
      4'b11_10: begin tap_x2 = 1'b1; tap_neg = 1'b1; end // c2 = -3
      4'b11_11: ;                                      // c3 = 1
      default: tap_x1 = 1'b0;
    endcase
  end

  always_comb begin
    e_ext    = acc_t'(e_sel);
    tap_term = (tap_x2 ? (e_ext <<< 1) : '0) + (tap_x1 ? e_ext : '0);
    acc_tap  = tap_neg ? (acc_q + tap_term) : (acc_q - tap_term);
  end

  // --------------------------------------------------------------------------
  // Quantiser: round half up (plus optional dither), saturate, form error.
  // --------------------------------------------------------------------------
  logic signed [Q_W-1:0]      dither;
  logic signed [Q_W-1:0]      q_sum, y_raw;
  logic signed [OUT_BITS-1:0] y_sat;
  logic signed [EQ_W-1:0]     e_full;
  err_t                       e_sat;

`ifdef DS_LFSR_DITHER_EN
  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  localparam logic [15:0] LFSR_TAPS = 16'hB400;
  logic [15:0] lfsr_q, lfsr_d;
  // Low bits re-centred on zero: range [-2^(FRAC_BITS-1), 2^(FRAC_BITS-1)-1].
  assign dither = Q_W'($signed({1'b0, lfsr_q[FRAC_BITS-1:0]})) - HALF;
`else
  assign dither = '0;
`endif

  always_comb begin
    q_sum = Q_W'(acc_q) + dither + HALF;
    y_raw = q_sum >>> FRAC_BITS;
    if (y_raw > Y_MAX)      y_sat = {1'b0, {(OUT_BITS-1){1'b1}}};
    else if (y_raw < Y_MIN) y_sat = {1'b1, {(OUT_BITS-1){1'b0}}};
    else                    y_sat = OUT_BITS'(y_raw);

    // Error is taken against the undithered accumulator.
    e_full = (EQ_W'(y_sat) <<< FRAC_BITS) - EQ_W'(acc_q);
    if (e_full > E_MAX)      e_sat = {1'b0, {(ERR_BITS-1){1'b1}}};
    else if (e_full < E_MIN) e_sat = {1'b1, {(ERR_BITS-1){1'b0}}};
    else                     e_sat = ERR_BITS'(e_full);
  end

  // --------------------------------------------------------------------------
  // Control FSM: next state and register updates.
  // --------------------------------------------------------------------------
  // Reset is gated in so no sample can be accepted while it is held.
  assign s_ready = (state_q == IDLE) && !reset;
  // An output slot is free when empty or being drained this cycle.
  assign commit  = (state_q == QUANT) && (!m_valid_q || bus.m_ready);

  always_comb begin
    state_d   = state_q;
    ch_d      = ch_q;
    order_d   = order_q;
    k_d       = k_q;
    acc_d     = acc_q;
    hist_d    = hist_q;
    m_valid_d = m_valid_q;
    m_ch_d    = m_ch_q;
    m_y_d     = m_y_q;
`ifdef DS_LFSR_DITHER_EN
    lfsr_d    = lfsr_q;
`endif

    if (m_valid_q && bus.m_ready) m_valid_d = 1'b0;

    case (state_q)
      IDLE: begin
        if (bus.s_valid && s_ready) begin
          ch_d    = bus.s_ch;
          order_d = bus.s_order;
          acc_d   = acc_t'(bus.s_u);
          k_d     = 2'd1;
          state_d = (bus.s_order == 2'd0) ? QUANT : TAP;
        end
      end
      TAP: begin
        acc_d = acc_tap;
        if (k_q == order_q) state_d = QUANT;
        else                k_d     = k_q + 2'd1;
      end
      QUANT: begin
        if (commit) begin
          m_valid_d = 1'b1;
          m_y_d     = y_sat;
          m_ch_d    = ch_q;
          if (order_q != 2'd0) begin
            hist_d[ch_q][2] = hist_q[ch_q][1];
            hist_d[ch_q][1] = hist_q[ch_q][0];
            hist_d[ch_q][0] = e_sat;
          end
`ifdef DS_LFSR_DITHER_EN
          lfsr_d = lfsr_q[0] ? ((lfsr_q >> 1) ^ LFSR_TAPS) : (lfsr_q >> 1);
`endif
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      ch_q      <= '0;
      order_q   <= '0;
      k_q       <= '0;
      acc_q     <= '0;
      m_valid_q <= 1'b0;
      m_ch_q    <= '0;
      m_y_q     <= '0;
      // NOTE: the history is a small flop array, not RAM, and a stale error
      // would leak into the first post-reset sample, so it is cleared here.
      for (int c = 0; c < NUM_CH; c++) begin
        for (int t = 0; t < 3; t++) hist_q[c][t] <= '0;
      end
`ifdef DS_LFSR_DITHER_EN
      lfsr_q    <= LFSR_SEED;
`endif
    end else begin
      // NOTE: non-blocking updates make every flop sample the same
      // pre-edge values regardless of statement order.
      state_q   <= state_d;
      ch_q      <= ch_d;
      order_q   <= order_d;
      k_q       <= k_d;
      acc_q     <= acc_d;
      hist_q    <= hist_d;
      m_valid_q <= m_valid_d;
      m_ch_q    <= m_ch_d;
      m_y_q     <= m_y_d;
`ifdef DS_LFSR_DITHER_EN
      lfsr_q    <= lfsr_d;
`endif
    end
  end

  assign bus.s_ready = s_ready;
  assign bus.m_valid = m_valid_q;
  assign bus.m_ch    = m_ch_q;
  assign bus.m_y     = m_y_q;

endmodule
